video_frame_monitor: RTL and testbench

//   Synthesizable in-line monitor on the stitched video output (video_vsync/video_de/video_data)

---
 rtl/video_frame_monitor.sv | 166 ++++++++++++++++
 tb/tb_video_frame_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_monitor.sv
// video_frame_monitor
//   In-line monitor for the stitched video stream. It measures the active width
//   and height of each frame, flags size and line-length errors, and counts
//   reported frames. A report is produced on every frame-start (vsync rising
//   edge) after the first one, with outputs valid two clocks after vsync rises
//   at the port.
//   Optional feature macro: VFM_CHECKSUM_EN adds a 32-bit per-frame pixel
//   checksum. When the macro is not defined, checksum is tied to zero.
module video_frame_monitor #(
    parameter int IMG_HDISP  = 1280,
    parameter int IMG_VDISP  = 720,
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  video_clk,
    input  logic                  rst_n,
    input  logic                  video_vsync,
    input  logic                  video_de,
    input  logic [DATA_WIDTH-1:0] video_data,
    output logic                  frame_done,
    output logic [7:0]            frame_cnt,
    output logic [CNT_WIDTH-1:0]  meas_hdisp,
    output logic [CNT_WIDTH-1:0]  meas_vdisp,
    output logic                  size_err,
    output logic [31:0]           checksum
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] HDISP_EXP  = CNT_WIDTH'(IMG_HDISP);
    localparam logic [CNT_WIDTH-1:0] VDISP_EXP  = CNT_WIDTH'(IMG_VDISP);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic                 s1_vsync, s1_de, s2_vsync, s2_de;
    logic [0:0]           state;
    logic [CNT_WIDTH-1:0] pix_cnt, line_cnt, hdisp_ref;
    logic                 line_err;

    logic                 vs_rise, de_fall, line_close, report;
    logic [CNT_WIDTH-1:0] pix_start, line_cnt_cl, hdisp_cl;
    logic                 line_err_cl;

    // Two-stage input pipeline; edge detection compares the two stages.
    always_ff @(posedge video_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, regardless of statement order.
        if (!rst_n) begin
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s2_vsync <= 1'b0;
            s2_de    <= 1'b0;
        end else begin
            s1_vsync <= video_vsync;
            s1_de    <= video_de;
            s2_vsync <= s1_vsync;
            s2_de    <= s1_de;
        end
    end

    // Edge detects and the line-close view of the accumulators, so a line that
    // ends on the frame-start cycle is folded into the frame being reported.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        vs_rise     = s1_vsync & ~s2_vsync;
        de_fall     = ~s1_de & s2_de;
        line_close  = (state == ST_ACTIVE) & (de_fall | (vs_rise & s2_de));
        report      = (state == ST_ACTIVE) & vs_rise;
        pix_start   = CNT_WIDTH'(s1_de);
        line_cnt_cl = line_cnt;
        hdisp_cl    = hdisp_ref;
        line_err_cl = line_err;
        if (line_close) begin
            line_cnt_cl = sat_inc(line_cnt);
            if (line_cnt == '0) begin
                hdisp_cl = pix_cnt;
            end else if (pix_cnt != hdisp_ref) begin
                line_err_cl = 1'b1;
            end
        end
    end

    // Frame FSM and per-frame pixel/line accumulators.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            hdisp_ref <= '0;
            line_err  <= 1'b0;
        end else if (state == ST_IDLE) begin
            // The partial frame seen before the first vsync is discarded.
            pix_cnt   <= vs_rise ? pix_start : '0;
            line_cnt  <= '0;
            hdisp_ref <= '0;
            line_err  <= 1'b0;
            if (vs_rise) state <= ST_ACTIVE;
        end else if (report) begin
            // The de cycle coincident with vs_rise belongs to the new frame.
            pix_cnt   <= pix_start;
            line_cnt  <= '0;
            hdisp_ref <= '0;
            line_err  <= 1'b0;
        end else begin
            if (line_close)  pix_cnt <= '0;
            else if (s1_de)  pix_cnt <= sat_inc(pix_cnt);
            line_cnt  <= line_cnt_cl;
            hdisp_ref <= hdisp_cl;
            line_err  <= line_err_cl;
        end
    end

    // Report registers: updated only on a report cycle, held otherwise.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            meas_hdisp <= '0;
            meas_vdisp <= '0;
            size_err   <= 1'b0;
        end else begin
            frame_done <= report;
            if (report) begin
                frame_cnt  <= frame_cnt + 8'd1;
                meas_hdisp <= hdisp_cl;
                meas_vdisp <= line_cnt_cl;
                size_err   <= line_err_cl | (hdisp_cl != HDISP_EXP) | (line_cnt_cl != VDISP_EXP);
            end
        end
    end

`ifdef VFM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] s1_data;
    logic [31:0]           csum_acc;

    // Pixel checksum: modulo-2^32 sum of every s1 de pixel, restarted per frame.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            s1_data  <= '0;
            csum_acc <= 32'h0;
            checksum <= 32'h0;
        end else begin
            s1_data <= video_data;
            if (vs_rise) begin
                csum_acc <= s1_de ? 32'(s1_data) : 32'h0;
            end else if (state == ST_ACTIVE && s1_de) begin
                csum_acc <= csum_acc + 32'(s1_data);
            end else if (state == ST_IDLE) begin
                csum_acc <= 32'h0;
            end
            if (report) checksum <= csum_acc;
        end
    end
`else
    // Pixel data is only needed by the checksum; fold it away when disabled.
    logic unused_data;
    assign unused_data = ^video_data;
    assign checksum    = 32'h0;
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
// tb_video_frame_monitor
//   Scoreboard bench: an input-level frame model pushes the expected report
//   whenever it drives a vsync rising edge on an active frame; a monitor pops
//   and compares on every frame_done. Uses a small 8x6 frame geometry.
module tb_video_frame_monitor;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int DW = 24;
    localparam int CW = 12;

    logic          video_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          video_vsync = 1'b0;
    logic          video_de = 1'b0;
    logic [DW-1:0] video_data = '0;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic [CW-1:0] meas_hdisp, meas_vdisp;
    logic          size_err;
    logic [31:0]   checksum;

    video_frame_monitor #(
        .IMG_HDISP(H), .IMG_VDISP(V), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .video_clk(video_clk), .rst_n(rst_n), .video_vsync(video_vsync),
        .video_de(video_de), .video_data(video_data), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .meas_hdisp(meas_hdisp), .meas_vdisp(meas_vdisp),
        .size_err(size_err), .checksum(checksum)
    );

    always #5 video_clk = ~video_clk;

    typedef struct {
        logic [CW-1:0] hd;
        logic [CW-1:0] vd;
        logic          err;
        logic [7:0]    cnt;
        logic [31:0]   sum;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Input-level frame model.
    bit          m_active, m_prev_vs, m_prev_de, m_bad;
    int          m_pix, m_lines, m_ref;
    logic [31:0] m_sum;
    logic [7:0]  m_cnt;

    task automatic m_close_line();
        if (m_lines == 0) m_ref = m_pix;
        else if (m_pix != m_ref) m_bad = 1'b1;
        m_lines++;
        m_pix = 0;
    endtask

    task automatic m_clear();
        m_pix = 0; m_lines = 0; m_ref = 0; m_bad = 1'b0; m_sum = 32'h0;
    endtask

    task automatic drive(input bit vs, input bit de, input logic [DW-1:0] d);
        exp_t e;
        @(negedge video_clk);
        video_vsync = vs;
        video_de    = de;
        video_data  = de ? d : '0;
        if (vs && !m_prev_vs) begin
            if (m_prev_de) m_close_line();
            if (m_active) begin
                m_cnt = m_cnt + 8'd1;
                e.hd  = CW'(m_ref);
                e.vd  = CW'(m_lines);
                e.err = m_bad || (m_ref != H) || (m_lines != V);
                e.cnt = m_cnt;
                e.sum = m_sum;
                sb.push_back(e);
            end
            m_active = 1'b1;
            m_clear();
        end else if (!de && m_prev_de) begin
            m_close_line();
        end
        if (de) begin
            m_pix++;
            m_sum = m_sum + 32'(d);
        end
        m_prev_vs = vs;
        m_prev_de = de;
    endtask

    function automatic logic [DW-1:0] pix_val(input int mode);
        return (mode == 0) ? DW'(1) : DW'($urandom);
    endfunction

    task automatic vsync_start();
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic send_line(input int len, input int mode, input bit vs_lvl, input int gap);
        for (int i = 0; i < len; i++) drive(vs_lvl, 1'b1, pix_val(mode));
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input int nl, input int bad_line, input int bad_len, input int mode);
        vsync_start();
        for (int l = 0; l < nl; l++) send_line((l == bad_line) ? bad_len : H, mode, 1'b0, 3);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge video_clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL report_timeout pending=%0d required=0", sb.size());
        end
    endtask

    // Scoreboard monitor: every frame_done must match the oldest expected report.
    always @(negedge video_clk) begin
        if (rst_n && frame_done) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_frame_done frame_cnt=%0d required=no report", frame_cnt);
            end else begin
                mon_e = sb.pop_front();
                n_vec += 5;
                if (meas_hdisp !== mon_e.hd) begin
                    n_err++; $display("FAIL meas_hdisp got=%0d exp=%0d", meas_hdisp, mon_e.hd);
                end
                if (meas_vdisp !== mon_e.vd) begin
                    n_err++; $display("FAIL meas_vdisp got=%0d exp=%0d", meas_vdisp, mon_e.vd);
                end
                if (size_err !== mon_e.err) begin
                    n_err++; $display("FAIL size_err got=%0b exp=%0b", size_err, mon_e.err);
                end
                if (frame_cnt !== mon_e.cnt) begin
                    n_err++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, mon_e.cnt);
                end
`ifdef VFM_CHECKSUM_EN
                if (checksum !== mon_e.sum) begin
                    n_err++; $display("FAIL checksum got=%h exp=%h", checksum, mon_e.sum);
                end
`else
                if (checksum !== 32'h0) begin
                    n_err++; $display("FAIL checksum got=%h exp=%h", checksum, 32'h0);
                end
`endif
            end
        end
    end

    task automatic apply_reset(input int cycles);
        @(negedge video_clk);
        rst_n = 1'b0; video_vsync = 1'b0; video_de = 1'b0; video_data = '0;
        repeat (cycles) @(negedge video_clk);
        n_vec += 6;
        if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        if (frame_cnt !== 8'd0)  begin n_err++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
        if (meas_hdisp !== '0)   begin n_err++; $display("FAIL rst_meas_hdisp got=%0d exp=0", meas_hdisp); end
        if (meas_vdisp !== '0)   begin n_err++; $display("FAIL rst_meas_vdisp got=%0d exp=0", meas_vdisp); end
        if (size_err !== 1'b0)   begin n_err++; $display("FAIL rst_size_err got=%b exp=0", size_err); end
        if (checksum !== 32'h0)  begin n_err++; $display("FAIL rst_checksum got=%h exp=0", checksum); end
        sb.delete();
        m_active = 1'b0; m_prev_vs = 1'b0; m_prev_de = 1'b0; m_cnt = 8'd0;
        m_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(3);
    endtask

    task automatic test_nominal();
        send_frame(V, -1, 0, 0);   // constant data 1: checksum = H*V
        send_frame(V, -1, 0, 1);   // random data
        vsync_start();
        wait_drain();
    endtask

    task automatic test_short_frame();
        send_frame(V - 1, -1, 0, 1);
        send_frame(V, -1, 0, 0);
        vsync_start();
        wait_drain();
    endtask

    task automatic test_short_line();
        send_frame(V, 2, H - 1, 1);
        vsync_start();
        wait_drain();
    endtask

    task automatic test_zero_frame();
        vsync_start();
        vsync_start();
        wait_drain();
    endtask

    task automatic test_midframe_reset();
        vsync_start();
        send_line(H, 0, 1'b0, 3);
        send_line(H, 0, 1'b0, 3);
        apply_reset(5);
        send_frame(V, -1, 0, 0);   // first vsync after reset: no report
        send_frame(V, -1, 0, 1);
        vsync_start();
        wait_drain();
        n_vec++;
        if (frame_cnt !== 8'd2) begin
            n_err++; $display("FAIL post_reset_frame_cnt got=%0d exp=2", frame_cnt);
        end
    endtask

    task automatic test_vsync_at_defall();
        vsync_start();
        for (int l = 0; l < V - 1; l++) send_line(H, 1, 1'b0, 3);
        send_line(H, 1, 1'b0, 0);  // de falls on the vsync rising cycle
        vsync_start();
        wait_drain();
        n_vec++;
        if (meas_vdisp !== CW'(V)) begin
            n_err++; $display("FAIL defall_line_kept got=%0d exp=%0d", meas_vdisp, V);
        end
    endtask

    task automatic test_de_high_at_vsync();
        vsync_start();
        for (int l = 0; l < V - 1; l++) send_line(H, 1, 1'b0, 3);
        send_line(H, 1, 1'b0, 0);
        send_line(H, 1, 1'b1, 3);  // first pixel coincides with vsync rising
        for (int l = 0; l < V - 1; l++) send_line(H, 1, 1'b0, 3);
        vsync_start();
        wait_drain();
    endtask

    task automatic test_wrap();
        apply_reset(2);
        for (int f = 0; f < 257; f++) send_frame(V, -1, 0, 0);
        vsync_start();
        wait_drain();
        n_vec += 2;
        if (frame_cnt !== 8'd1) begin
            n_err++; $display("FAIL wrap_frame_cnt got=%0d exp=1", frame_cnt);
        end
        if (size_err !== 1'b0) begin
            n_err++; $display("FAIL wrap_size_err got=%b exp=0", size_err);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_frame();
        test_short_line();
        test_zero_frame();
        test_midframe_reset();
        test_vsync_at_defall();
        test_de_high_at_vsync();
        test_wrap();
        repeat (5) @(negedge video_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
